ifetch_unit: RTL and testbench

//   Fetch-side consumer of the fetch PC. Takes PC_F from the PC register and issues

---
 rtl/ifetch_unit.sv | 109 ++++++++++
 tb/tb_ifetch_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// ifetch_unit: issues instruction-memory fetches for PC_F and buffers returned words in a show-ahead FIFO.
// Define IFETCH_PERF_EN to add the perf_stall_cnt / perf_flush_cnt counter outputs.
module ifetch_unit #(
   parameter int          FIFO_DEPTH = 2,
   parameter logic [31:0] RESET_PC   = 32'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] PC_F,
   input  logic        PC_src,
   output logic        stall_F,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr_D,
   output logic [31:0] instr_pc_D,
   input  logic        instr_ready
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
   state_t          state_q, state_d;
   logic [31:0]     pc_tag_q, pc_tag_d;
   logic [31:0]     dat_q [FIFO_DEPTH];
   logic [31:0]     pcm_q [FIFO_DEPTH];
   logic [PW-1:0]   wr_q, rd_q;
   logic [CW-1:0]   cnt_q;
   logic [31:0]     dat_hold_q, pc_hold_q;
   logic [CW:0]     lvl;
   logic            push, pop, hs;
   always_comb begin
      push        = (state_q == WAIT) & imem_rvalid & !PC_src;
      instr_valid = cnt_q != '0;
      pop         = instr_valid & instr_ready & !PC_src;
      lvl         = {1'b0, cnt_q} + (CW+1)'(push) - (CW+1)'(pop);
      // rst_n gate keeps the request quiet while reset is held
      imem_req    = rst_n & !PC_src & ((state_q == IDLE) | ((state_q == WAIT) & imem_rvalid))
                    & (lvl < (CW+1)'(FIFO_DEPTH));
      hs          = imem_req & imem_gnt;
      stall_F     = !PC_src & !hs;
      imem_addr   = PC_F;
      instr_D     = instr_valid ? dat_q[rd_q] : dat_hold_q;
      instr_pc_D  = instr_valid ? pcm_q[rd_q] : pc_hold_q;
      pc_tag_d    = hs ? PC_F : pc_tag_q;
      state_d     = state_q;
      unique case (state_q)
         IDLE:    state_d = hs ? WAIT : IDLE;
         WAIT:    state_d = PC_src ? (imem_rvalid ? IDLE : DROP)
                                   : (imem_rvalid ? (hs ? WAIT : IDLE) : WAIT);
         DROP:    state_d = imem_rvalid ? IDLE : DROP;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pc_tag_q   <= RESET_PC;
         wr_q       <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
         dat_hold_q <= '0;
         pc_hold_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            dat_q[i] <= '0;
            pcm_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         pc_tag_q   <= pc_tag_d;
         dat_hold_q <= instr_D;
         pc_hold_q  <= instr_pc_D;
         if (PC_src) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
         end else begin
            if (push) begin
               dat_q[wr_q] <= imem_rdata;
               pcm_q[wr_q] <= pc_tag_q;
               wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            cnt_q <= lvl[CW-1:0];
         end
      end
   end
`ifdef IFETCH_PERF_EN
   logic [31:0] perf_stall_q, perf_flush_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         perf_stall_q <= perf_stall_q + {31'b0, stall_F};
         perf_flush_q <= perf_flush_q + {31'b0, PC_src};
      end
   end
   assign perf_stall_cnt = perf_stall_q;
   assign perf_flush_cnt = perf_flush_q;
`endif
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: drives ifetch_unit with a PC-register and 1..N-cycle memory model; returned words are scoreboarded.
module tb_ifetch_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] PC_F = '0;
   logic        PC_src = 1'b0;
   logic        stall_F, imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0, instr_valid, instr_ready = 1'b0;
   logic [31:0] imem_addr, imem_rdata = '0, instr_D, instr_pc_D;
`ifdef IFETCH_PERF_EN
   logic [31:0] perf_stall_cnt, perf_flush_cnt;
   logic [31:0] perf_before;
`endif
   int          tests = 0, fails = 0;
   int          lat = 1, pcnt = 0;
   logic [31:0] target = '0, paddr = '0, addr_s = '0, a0;
   logic        hs_s = 1'b0, src_s = 1'b0, stall_s = 1'b1;
   logic [63:0] sb [$];
   logic [63:0] exp_e;

   ifetch_unit dut (
      .clk(clk), .rst_n(rst_n), .PC_F(PC_F), .PC_src(PC_src), .stall_F(stall_F),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
      .instr_D(instr_D), .instr_pc_D(instr_pc_D), .instr_ready(instr_ready)
`ifdef IFETCH_PERF_EN
      , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h0BAD_F00D;
   endfunction

   // Scoreboard: expected word queued at each handshake, checked at each pop, cleared by a flush.
   always @(negedge clk) begin
      if (!rst_n) begin
         hs_s = 1'b0; src_s = 1'b0; stall_s = 1'b1;
      end else begin
         hs_s = imem_req & imem_gnt; addr_s = imem_addr; src_s = PC_src; stall_s = stall_F;
         if (PC_src) sb.delete();
         else begin
            if (instr_valid & instr_ready) begin
               tests++;
               if (sb.size() == 0) begin
                  fails++;
                  $display("FAIL sb_pop: got pc=%h instr=%h, expected no word", instr_pc_D, instr_D);
               end else begin
                  exp_e = sb.pop_front();
                  if ({instr_pc_D, instr_D} !== exp_e) begin
                     fails++;
                     $display("FAIL sb_pop: got pc=%h instr=%h, expected pc=%h instr=%h",
                              instr_pc_D, instr_D, exp_e[63:32], exp_e[31:0]);
                  end
               end
            end
            if (hs_s) sb.push_back({imem_addr, memf(imem_addr)});
         end
      end
   end

   // Environment: PC register and memory responding lat cycles after each grant.
   initial forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
         PC_F = '0; pcnt = 0; imem_rvalid = 1'b0;
      end else begin
         imem_rvalid = 1'b0;
         if (hs_s) begin pcnt = lat; paddr = addr_s; end
         if (pcnt > 0) begin
            pcnt--;
            if (pcnt == 0) begin imem_rvalid = 1'b1; imem_rdata = memf(paddr); end
         end
         if (src_s) PC_F = target;
         else if (!stall_s) PC_F = PC_F + 32'd4;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      @(negedge clk);
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b expected 0", imem_req); end
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
      tests++; if (instr_D !== 32'h0) begin fails++; $display("FAIL rst_instr: got %h expected 0", instr_D); end
      tests++; if (instr_pc_D !== 32'h0) begin fails++; $display("FAIL rst_pc: got %h expected 0", instr_pc_D); end
      tests++; if (stall_F !== 1'b1) begin fails++; $display("FAIL rst_stall: got %b expected 1", stall_F); end
`ifdef IFETCH_PERF_EN
      tests++; if (perf_stall_cnt !== 32'h0) begin fails++; $display("FAIL rst_perf_stall: got %h expected 0", perf_stall_cnt); end
`endif
   endtask

   task automatic test_stream();
      imem_gnt = 1'b1; instr_ready = 1'b1; lat = 1;
      tick(); rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         tests++; if (stall_F !== 1'b0) begin fails++; $display("FAIL stream_stall c%0d: got %b expected 0", i, stall_F); end
         if (i >= 2) begin
            tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL stream_valid c%0d: got %b expected 1", i, instr_valid); end
         end
         if (i == 2) begin
            tests++; if (instr_pc_D !== 32'h0) begin fails++; $display("FAIL stream_first_pc: got %h expected 0", instr_pc_D); end
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      instr_ready = 1'b0;
      repeat (4) tick();
      @(negedge clk);
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL bp_req: got %b expected 0", imem_req); end
      tests++; if (stall_F !== 1'b1) begin fails++; $display("FAIL bp_stall: got %b expected 1", stall_F); end
      tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL bp_valid: got %b expected 1", instr_valid); end
      tick(); instr_ready = 1'b1;
      tick();
      @(negedge clk);
      tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL bp_resume_req: got %b expected 1", imem_req); end
      tests++; if (stall_F !== 1'b0) begin fails++; $display("FAIL bp_resume_stall: got %b expected 0", stall_F); end
      repeat (4) tick();
   endtask

   task automatic test_gnt_stall();
      a0 = PC_F; imem_gnt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests++; if (stall_F !== 1'b1) begin fails++; $display("FAIL gnt_stall c%0d: got %b expected 1", i, stall_F); end
         tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL gnt_req c%0d: got %b expected 1", i, imem_req); end
         tests++; if (imem_addr !== a0) begin fails++; $display("FAIL gnt_addr c%0d: got %h expected %h", i, imem_addr, a0); end
         tick();
      end
      imem_gnt = 1'b1;
      repeat (4) tick();
   endtask

   task automatic test_flush_wait();
      imem_gnt = 1'b0;
      tick(); lat = 3; imem_gnt = 1'b1;
      tick(); PC_src = 1'b1; target = 32'h100;
      @(negedge clk);
      tests++; if (stall_F !== 1'b0) begin fails++; $display("FAIL fw_stall: got %b expected 0", stall_F); end
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL fw_req: got %b expected 0", imem_req); end
`ifdef IFETCH_PERF_EN
      perf_before = perf_flush_cnt;
`endif
      tick(); PC_src = 1'b0;
      @(negedge clk);
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL fw_drop_req: got %b expected 0", imem_req); end
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL fw_drop_valid: got %b expected 0", instr_valid); end
`ifdef IFETCH_PERF_EN
      tests++; if (perf_flush_cnt !== perf_before + 32'd1) begin fails++; $display("FAIL fw_perf_flush: got %h expected %h", perf_flush_cnt, perf_before + 32'd1); end
`endif
      tick(); lat = 1;
      @(negedge clk);
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL fw_stale_req: got %b expected 0", imem_req); end
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL fw_stale_valid: got %b expected 0", instr_valid); end
      tick();
      @(negedge clk);
      tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL fw_target_req: got %b expected 1", imem_req); end
      tests++; if (imem_addr !== 32'h100) begin fails++; $display("FAIL fw_target_addr: got %h expected 100", imem_addr); end
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL fw_target_valid: got %b expected 0", instr_valid); end
      repeat (5) tick();
   endtask

   task automatic test_flush_rvalid();
      PC_src = 1'b1; target = 32'h200; instr_ready = 1'b0;
      @(negedge clk);
      tests++; if (stall_F !== 1'b0) begin fails++; $display("FAIL fr_stall: got %b expected 0", stall_F); end
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL fr_req: got %b expected 0", imem_req); end
      tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL fr_valid_before: got %b expected 1", instr_valid); end
      tick(); PC_src = 1'b0; instr_ready = 1'b1;
      @(negedge clk);
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL fr_empty: got %b expected 0", instr_valid); end
      tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL fr_idle_req: got %b expected 1", imem_req); end
      tests++; if (imem_addr !== 32'h200) begin fails++; $display("FAIL fr_addr: got %h expected 200", imem_addr); end
      tick();
      @(negedge clk);
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL fr_wait_valid: got %b expected 0", instr_valid); end
      tick();
      @(negedge clk);
      tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL fr_target_valid: got %b expected 1", instr_valid); end
      tests++; if (instr_pc_D !== 32'h200) begin fails++; $display("FAIL fr_target_pc: got %h expected 200", instr_pc_D); end
      repeat (3) tick();
   endtask

   task automatic test_reset_mid();
      rst_n = 1'b0; imem_rvalid = 1'b0; sb.delete();
      #1;
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL mid_req: got %b expected 0", imem_req); end
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL mid_valid: got %b expected 0", instr_valid); end
      tests++; if (instr_D !== 32'h0) begin fails++; $display("FAIL mid_instr: got %h expected 0", instr_D); end
      tests++; if (instr_pc_D !== 32'h0) begin fails++; $display("FAIL mid_pc: got %h expected 0", instr_pc_D); end
      tests++; if (stall_F !== 1'b1) begin fails++; $display("FAIL mid_stall: got %b expected 1", stall_F); end
`ifdef IFETCH_PERF_EN
      tests++; if (perf_stall_cnt !== 32'h0) begin fails++; $display("FAIL mid_perf_stall: got %h expected 0", perf_stall_cnt); end
      tests++; if (perf_flush_cnt !== 32'h0) begin fails++; $display("FAIL mid_perf_flush: got %h expected 0", perf_flush_cnt); end
`endif
      repeat (2) tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         tests++; if (stall_F !== 1'b0) begin fails++; $display("FAIL mid_restart_stall c%0d: got %b expected 0", i, stall_F); end
         if (i == 2) begin
            tests++; if (instr_pc_D !== 32'h0) begin fails++; $display("FAIL mid_restart_pc: got %h expected 0", instr_pc_D); end
         end
         tick();
      end
   endtask

   task automatic test_drain();
      imem_gnt = 1'b0;
      repeat (4) tick();
      @(negedge clk);
      tests++; if (sb.size() != 0) begin fails++; $display("FAIL drain_sb: got %0d words left expected 0", sb.size()); end
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL drain_valid: got %b expected 0", instr_valid); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_gnt_stall();
      test_flush_wait();
      test_flush_rvalid();
      test_reset_mid();
      test_drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
